// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue path.
// Pure declarations; no logic, no latency, no flow control.
// Consumers import alu_pkg::* for the instruction layout and bubble encoding.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t    ALUOP_NOP    = 4'h0;
    localparam logic [7:0] PIPE1_BUBBLE = 8'h00;

    // Instruction byte layout: opcode in the upper nibble feeds ALU_Control.
    typedef struct packed {
        alu_op_t    op;
        logic [3:0] sel;
    } instr_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// 2-entry instruction queue with push/pop/flush, head data visible combinationally.
// Latency: a pushed entry is visible at head_dat one edge after the push.
// Backpressure: caller must not push when full; flush empties it at the edge.
module alu_issue_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_vld,
    input  instr_t push_dat,
    input  logic   pop,
    input  logic   flush,
    output logic   empty,
    output logic   full,
    output instr_t head_dat
);

    instr_t     mem_q [2];
    instr_t     mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_vld) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = !rd_ptr_q;
            end
            count_d = count_q + 2'(push_vld) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: instr_t'(PIPE1_BUBBLE)};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign empty    = (count_q == 2'd0);
    assign full     = (count_q == 2'(DEPTH));
    assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_op_issue.sv
// Pipe1 issue stage feeding ALU_Control; ALU_ISSUE_STATS_EN adds issue/stall counters.
// Latency: bypass loads Pipe1 on the accepting edge when queue empty and enabled.
// Backpressure: InstrReady drops when the 2-entry queue is full or Flush is high.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
`ifdef ALU_ISSUE_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 InstrValid,
    input  logic [7:0]           InstrByte,
    output logic                 InstrReady,
    input  logic                 StageEnable,
    input  logic                 Flush,
    output logic [3:0]           Pipe1Out_0_3,
    output logic                 Pipe1Out_4_ALUOP0,
    output logic                 Pipe1Out_5_ALUOP1,
    output logic                 Pipe1Out_6_ALUOP2,
    output logic                 Pipe1Out_7_ALUOP3,
    output logic                 Pipe1Valid
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [CNT_W-1:0]     IssueCount,
    output logic [CNT_W-1:0]     StallCount
`endif
);

    logic   fifo_empty, fifo_full;
    logic   fifo_push, fifo_pop;
    logic   push;
    logic   issue;
    instr_t head_dat;
    instr_t pipe1_q, pipe1_d;
    logic   pipe1_vld_q, pipe1_vld_d;

    assign InstrReady = !fifo_full && !Flush;
    assign push       = InstrValid && InstrReady;

    alu_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (Clock),
        .rst_n    (Reset_n),
        .push_vld (fifo_push),
        .push_dat (instr_t'(InstrByte)),
        .pop      (fifo_pop),
        .flush    (Flush),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .head_dat (head_dat)
    );

    always_comb begin
        pipe1_d     = pipe1_q;
        pipe1_vld_d = pipe1_vld_q;
        fifo_push   = push;
        fifo_pop    = 1'b0;
        if (Flush) begin
            pipe1_d     = instr_t'(PIPE1_BUBBLE);
            pipe1_vld_d = 1'b0;
        end else if (StageEnable) begin
            if (!fifo_empty) begin
                fifo_pop    = 1'b1;
                pipe1_d     = head_dat;
                pipe1_vld_d = 1'b1;
            end else if (push) begin
                // Empty queue: skip the FIFO so a lone instruction issues with no extra cycle.
                fifo_push   = 1'b0;
                pipe1_d     = instr_t'(InstrByte);
                pipe1_vld_d = 1'b1;
            end else begin
                pipe1_d     = instr_t'(PIPE1_BUBBLE);
                pipe1_vld_d = 1'b0;
            end
        end
        issue = !Flush && StageEnable && pipe1_vld_d;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pipe1_q     <= instr_t'(PIPE1_BUBBLE);
            pipe1_vld_q <= 1'b0;
        end else begin
            pipe1_q     <= pipe1_d;
            pipe1_vld_q <= pipe1_vld_d;
        end
    end

    assign Pipe1Out_0_3      = pipe1_q.sel;
    assign Pipe1Out_4_ALUOP0 = pipe1_q.op[0];
    assign Pipe1Out_5_ALUOP1 = pipe1_q.op[1];
    assign Pipe1Out_6_ALUOP2 = pipe1_q.op[2];
    assign Pipe1Out_7_ALUOP3 = pipe1_q.op[3];
    assign Pipe1Valid        = pipe1_vld_q;

`ifdef ALU_ISSUE_STATS_EN
    logic             stall;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counters saturate and survive Flush; only reset clears them.
    always_comb begin
        stall       = !StageEnable && pipe1_vld_q && !Flush;
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (issue && (issue_cnt_q != '1)) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign IssueCount = issue_cnt_q;
    assign StallCount = stall_cnt_q;
`else
    logic unused_issue;
    assign unused_issue = issue;
`endif

endmodule
